// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the I/D memory arbiter.
package mem_arb_pkg;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between I-cache refills and
// D-cache refills/write-backs, D-priority with an I starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W       = mem_arb_pkg::DATA_W,
    parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_ack_o,
    output logic [DATA_W-1:0] ic_data_o,
    input  logic              dc_req_i,
    input  logic              dc_write_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_data_i,
    output logic              dc_ack_o,
    output logic [DATA_W-1:0] dc_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);
    state_t            r_state, w_next;
    owner_t            r_owner;
    logic [3:0]        r_starve;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_ic_data, r_dc_data;
    logic              r_write, r_en, r_ic_ack, r_dc_ack;
    logic              w_req, w_grant_i, w_cap;

    // D wins ties unless I has waited through STARVE_LIMIT D grants
    always_comb begin
        w_req     = ic_req_i | dc_req_i;
        w_grant_i = ic_req_i & (~dc_req_i | (r_starve == 4'(STARVE_LIMIT)));
        w_cap     = (r_state == BUSY) & mem_ack_i & ~r_write;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? BUSY : IDLE;
            BUSY:    w_next = mem_ack_i ? RESP : BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = r_state != IDLE;
        mem_enable_o = r_en;
        mem_write_o  = r_write;
        mem_addr_o   = r_addr;
        mem_data_o   = r_wdata;
        ic_ack_o     = r_ic_ack;
        dc_ack_o     = r_dc_ack;
        ic_data_o    = r_ic_data;
        dc_data_o    = r_dc_data;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner   <= OWN_I;
            r_starve  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_en      <= 1'b0;
            r_ic_ack  <= 1'b0;
            r_dc_ack  <= 1'b0;
            r_ic_data <= '0;
            r_dc_data <= '0;
        end else begin
            r_en     <= w_next == BUSY;
            r_ic_ack <= (w_next == RESP) & (r_owner == OWN_I);
            r_dc_ack <= (w_next == RESP) & (r_owner == OWN_D);
            if (r_state == IDLE && w_req) begin
                r_owner  <= w_grant_i ? OWN_I : OWN_D;
                r_addr   <= w_grant_i ? ic_addr_i : dc_addr_i;
                r_write  <= ~w_grant_i & dc_write_i;
                r_wdata  <= w_grant_i ? '0 : dc_data_i;
                r_starve <= w_grant_i ? 4'd0 :
                            (ic_req_i && r_starve != 4'hF) ? r_starve + 4'd1 : r_starve;
            end
            if (w_cap && r_owner == OWN_I) r_ic_data <= mem_data_i;
            if (w_cap && r_owner == OWN_D) r_dc_data <= mem_data_i;
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256-bit off-chip memory port between the instruction-cache refill path and the data-cache refill/write-back path. It sits between both caches and the memory model, and runs one line transaction at a time. The data cache normally wins contention because its misses freeze the whole pipeline through `mem_stall`. A starvation counter guarantees the instruction cache forward progress.

## Interface
- `DATA_W`, 256, line width in bits
- `ADDR_W`, 32, byte address width
- `STARVE_LIMIT`, 4, consecutive D grants tolerated while I is pending (1..15)

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  reset; one clock, reset asynchronous and active-low
- `ic_req_i`  in  1  I-cache line read request; level, held until `ic_ack_o`
- `ic_addr_i`  in  ADDR_W  I-cache line address; stable while `ic_req_i`
- `ic_ack_o`  out  1  one-cycle completion pulse to I-cache
- `ic_data_o`  out  DATA_W  returned line; valid in the `ic_ack_o` cycle
- `dc_req_i`  in  1  D-cache request; level, held until `dc_ack_o`
- `dc_write_i`  in  1  1 = line write-back, 0 = line read
- `dc_addr_i`  in  ADDR_W  D-cache line address
- `dc_data_i`  in  DATA_W  write-back line
- `dc_ack_o`  out  1  one-cycle completion pulse to D-cache
- `dc_data_o`  out  DATA_W  returned line on reads
- `mem_enable_o`  out  1  memory request; held high until `mem_ack_i`
- `mem_write_o`  out  1  write strobe for the current transaction
- `mem_addr_o`  out  ADDR_W  transaction address
- `mem_data_o`  out  DATA_W  write data
- `mem_data_i`  in  DATA_W  read data; valid with `mem_ack_i`
- `mem_ack_i`  in  1  one-cycle completion pulse from memory
- `busy_o`  out  1  high in every state except IDLE

## Operation
The arbiter is a three-state FSM with states IDLE, BUSY and RESP, plus an `owner` register holding I or D.
- **IDLE**: requests are sampled here.
  - If neither request is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant D, unless `starve_cnt == STARVE_LIMIT`, in which case grant I.
  - On a grant, latch owner, address, write flag and write data into registers, then go to BUSY.
- **BUSY**: `mem_enable_o` = 1 and the latched attributes drive the `mem_*` outputs.
  - On `mem_ack_i`: if this is a read, capture `mem_data_i` into the owner's data register. Go to RESP.
- **RESP**: pulse the owner's ack for exactly one cycle, then return to IDLE.
  - The requester must drop `req` on the edge that ends the RESP cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- **`starve_cnt`** (4-bit saturating counter):
  - Increments on each D grant made while `ic_req_i` = 1.
  - Clears on every I grant.
  - Holds otherwise.
- **Write-backs**:
  - `dc_data_o` keeps its previous value on D writes.
  - `ic_data_o` and `dc_data_o` change only on read captures for their owner.
- **Ignored inputs**:
  - `mem_ack_i` is ignored outside BUSY.
  - Request-attribute changes during BUSY are ignored, because the latched copies drive memory.
- **Reset**:
  - Every register and every output is 0: state IDLE, `starve_cnt` 0, both data registers 0.
  - Reset mid-transaction abandons the transaction with no ack. The memory model must tolerate `mem_enable_o` dropping before ack.

## Timing
- If `req` is first high in IDLE cycle 0, `mem_enable_o` rises at cycle 1.
- If `mem_ack_i` arrives at cycle k (k ≥ 1), the requester's ack pulses at cycle k+1 and the FSM is in IDLE at k+2.
- Minimum request-to-ack latency is 2 cycles, for a memory that acks in the first enable cycle.
- Back-to-back transactions are separated by at least one IDLE cycle.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered outputs, glitch-free and stable for the whole of BUSY.
- Acks are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum `{IDLE, BUSY, RESP}`
  - owner encoding `OWN_I = 0`, `OWN_D = 1`
  - `DATA_W` and `ADDR_W` defaults, shared with `Data_Cache`
- No sub-module. The grant decision is a few lines of combinational logic in the same file.

## Test plan
- **Single I read**: `ic_req_i` with addr 0x0000_0040, memory acks after 3 cycles with data A5…A5. Expect `mem_enable_o` high for 3 cycles with `mem_write_o` = 0, then `ic_ack_o` for 1 cycle and `ic_data_o` = A5…A5.
- **D write-back**: `dc_write_i` = 1, addr 0x0000_0100, data 0x1234…, memory acks after 1 cycle. Expect `mem_write_o` = 1 and `mem_data_o` = 0x1234…, then `dc_ack_o`; `dc_data_o` stays unchanged.
- **Simultaneous requests**: both requests first high in the same IDLE cycle. Expect D granted first, I granted in the next IDLE cycle, and `starve_cnt` = 1 after the D grant and 0 after the I grant.
- **Starvation**: D re-requests continuously, I held high, `STARVE_LIMIT` = 4. Expect 4 D grants, then an I grant on the 5th arbitration even though D is pending.
- **Spurious ack**: `mem_ack_i` pulsed in IDLE. Expect no state change and no ack output.
- **Reset mid-transaction**: `rst_i` driven low during BUSY. Expect all outputs 0 immediately (asynchronous). After release, a fresh `ic_req_i` completes normally.
